boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Upstream feeder for the pipelined CPU's instruction-load path.
- Accepts a byte stream from a host link and assembles it into 32-bit instruction words in an internal buffer.
- Holds the CPU in reset while it buffers, then streams the words back-to-back on LoadInstructions/Instruction, one per cycle, starting when the CPU's load address counter leaves reset at 0.
- After streaming, pulses CPU reset once so the PC restarts at 0, then releases the CPU to run.

Parameters:
- DEPTH, 32, maximum program length in words (2..255).
- AW, 5, buffer index width; must satisfy 2^AW >= DEPTH.
- TIMEOUT, 1024, maximum idle cycles between data bytes before an error is flagged.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- load_req  in  1  single-cycle request to start a load.
- byte_valid  in  1  host byte present.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- CpuReset  out  1  drives the CPU Reset input.
- LoadInstructions  out  1  drives the CPU LoadInstructions input.
- Instruction  out  32  drives the CPU Instruction input.
- busy  out  1  high in states HDR, DATA, CSUM, STREAM and RESTART.
- done  out  1  high in state RUN.
- error  out  1  high in state ERR.

Behaviour:
- Reset values: state=IDLE, CpuReset=1, LoadInstructions=0, Instruction=0, byte_ready=0, busy=0, done=0, error=0. All counters are 0.
- Reset asserted mid-operation: return to IDLE at the next edge. Buffer contents are don't-care.
- Byte transfer: occurs on a cycle with byte_valid & byte_ready. byte_ready=1 only in HDR, DATA and CSUM.
- IDLE: CpuReset=1. On load_req, go to HDR.
- HDR: the first transferred byte is the word count N.
  - N=0 or N>DEPTH: go to ERR.
  - Otherwise latch N and go to DATA.
  - HDR has no timeout.
- DATA:
  - Bytes are packed MSB first, four bytes per word.
  - The 4th byte writes the word to buf[widx] and increments widx.
  - After word N-1 is written, go to CSUM if CHECKSUM_EN is defined, else go to STREAM.
  - An idle counter clears on every transfer. If it reaches TIMEOUT with no transfer, go to ERR.
- STREAM: N consecutive cycles, k=0..N-1.
  - CpuReset=0, LoadInstructions=1, Instruction=buf[k].
  - On the cycle after the last word, go to RESTART.
  - CpuReset deasserts on the first STREAM cycle, so the CPU counter reads address 0 with word 0.
- RESTART: exactly one cycle with CpuReset=1, LoadInstructions=0, Instruction=0. Then go to RUN.
- RUN: CpuReset=0, done=1. load_req goes to HDR and reasserts CpuReset on the next cycle.
- ERR: CpuReset=1, error=1. load_req clears error and goes to HDR.
- Outside STREAM: LoadInstructions=0 and Instruction=0.
- load_req is ignored in HDR, DATA, CSUM, STREAM and RESTART.
- byte_valid while byte_ready=0: no transfer, and the byte is not consumed.
- N=DEPTH: the buffer fills exactly. widx must not wrap before STREAM.
- Simultaneous Reset and load_req: Reset wins.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps an 8-bit modulo-256 sum of the N*4 data bytes, excluding the header.
  - State CSUM accepts one extra byte, with the same TIMEOUT rule as DATA.
  - Byte equals the sum: go to STREAM. Otherwise go to ERR; nothing is streamed and CpuReset stays high.
- Not defined: state CSUM and the sum logic are absent. DATA goes directly to STREAM.

Test Plan:
- Reset, then load_req, then bytes 02, 20 01 00 05, 8C 02 00 00, delivered back-to-back:
  - LoadInstructions=1 for exactly 2 cycles carrying 0x20010005 then 0x8C020000, with CpuReset=0.
  - The next cycle has CpuReset=1; then done=1 and CpuReset=0.
- Header 00 → error=1, CpuReset=1 and no LoadInstructions pulse. A following load_req plus a valid stream recovers to done=1.
- Header = DEPTH (0x20) with 128 bytes of incrementing words → exactly 32 STREAM cycles in order, word k = buf[k], with no wrap.
- Header 01, then 3 data bytes, then an idle gap of TIMEOUT cycles → error=1. Reset assertion during DATA → IDLE with all outputs at reset values.
- With BOOT_LOADER_CHECKSUM_EN defined, header 01, data 01 02 03 04:
  - Checksum byte 0x0A → streams 0x01020304.
  - Checksum byte 0x0B → error=1, no streaming.
- byte_valid held high with stalled data during STREAM/RUN → byte_ready=0 and nothing is consumed. load_req during STREAM is ignored, and streaming still completes N words.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: packs a host byte stream into 32-bit words, then streams them into the CPU load path.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte after the data.
module boot_loader #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        load_req,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        CpuReset,
  output logic        LoadInstructions,
  output logic [31:0] Instruction,
  output logic        busy,
  output logic        done,
  output logic        error
);
  // state   | meaning
  // IDLE    | waiting for load_req, CPU held in reset
  // HDR     | expecting the word-count byte
  // DATA    | packing data bytes MSB first into words
  // CSUM    | expecting the checksum byte (checksum build only)
  // STREAM  | one buffered word per cycle into the CPU
  // RESTART | single CPU reset pulse so the PC restarts at 0
  // RUN     | CPU released
  // ERR     | bad header, bad checksum or timeout; CPU held in reset
`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, STREAM, RESTART, RUN, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, STREAM, RESTART, RUN, ERR} state_t;
`endif

  localparam int unsigned   IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(TIMEOUT - 1);

  state_t          state, nxt;
  logic [7:0]      n_words;
  logic [AW-1:0]   widx, ridx, rd_idx;
  logic [1:0]      byte_cnt;
  logic [23:0]     shift;
  logic [IW-1:0]   idle_left;
  logic            xfer, wr_en, last_word, last_stream, bad_hdr, accept_nxt, timed_phase;
  logic [31:0]     word_new, rd_word;
  logic [31:0]     mem [0:DEPTH-1];
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]      sum;
`endif

  assign xfer        = byte_valid & byte_ready;
  assign word_new    = {shift, byte_data};
  assign wr_en       = xfer && (state == DATA) && (byte_cnt == 2'd3);
  assign last_word   = widx == AW'(n_words - 8'd1);
  assign last_stream = ridx == AW'(n_words - 8'd1);
  assign bad_hdr     = (byte_data == 8'd0) || (byte_data > 8'(DEPTH));
  assign rd_idx      = (state == STREAM) ? ridx + AW'(1) : '0;
  // A one-word program enters STREAM on the same edge its word is written.
  assign rd_word     = (wr_en && (widx == rd_idx)) ? word_new : mem[rd_idx];

  always_comb begin
    nxt         = state;
    timed_phase = (state == DATA);
    unique case (state)
      IDLE: if (load_req) nxt = HDR;
      HDR:  if (xfer) nxt = bad_hdr ? ERR : DATA;
      DATA: begin
        if (wr_en && last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          nxt = CSUM;
`else
          nxt = STREAM;
`endif
        end else if (!xfer && (idle_left == '0)) begin
          nxt = ERR;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CSUM: begin
        timed_phase = 1'b1;
        if (xfer) nxt = (byte_data == sum) ? STREAM : ERR;
        else if (idle_left == '0) nxt = ERR;
      end
`endif
      STREAM:   if (last_stream) nxt = RESTART;
      RESTART:  nxt = RUN;
      RUN, ERR: if (load_req) nxt = HDR;
      default:  nxt = IDLE;
    endcase
    accept_nxt = (nxt == HDR) || (nxt == DATA);
`ifdef BOOT_LOADER_CHECKSUM_EN
    accept_nxt = accept_nxt || (nxt == CSUM);
`endif
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state            <= IDLE;
      CpuReset         <= 1'b1;
      LoadInstructions <= 1'b0;
      Instruction      <= '0;
      byte_ready       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      n_words          <= '0;
      widx             <= '0;
      ridx             <= '0;
      byte_cnt         <= '0;
      shift            <= '0;
      idle_left        <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum              <= '0;
`endif
    end else begin
      state            <= nxt;
      CpuReset         <= !((nxt == STREAM) || (nxt == RUN));
      LoadInstructions <= (nxt == STREAM);
      Instruction      <= (nxt == STREAM) ? rd_word : '0;
      byte_ready       <= accept_nxt;
      busy             <= accept_nxt || (nxt == STREAM) || (nxt == RESTART);
      done             <= (nxt == RUN);
      error            <= (nxt == ERR);
      if (nxt == STREAM) ridx <= rd_idx;
      if ((state == HDR) && xfer) begin
        n_words   <= byte_data;
        widx      <= '0;
        byte_cnt  <= '0;
        idle_left <= IDLE_LOAD;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum       <= '0;
`endif
      end
      if (timed_phase) begin
        if (xfer) idle_left <= IDLE_LOAD;
        else if (idle_left != '0) idle_left <= idle_left - IW'(1);
      end
      if ((state == DATA) && xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {shift[15:0], byte_data};
        // widx holds at the last word so a full buffer never wraps
        if (wr_en && !last_word) widx <= widx + AW'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum      <= sum + byte_data;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= word_new;
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: scoreboard bench; expected words are queued as bytes are sent and popped as the DUT streams.
// Checksum cases run only when BOOT_LOADER_CHECKSUM_EN is defined.
module tb_boot_loader;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        Reset, load_req, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, CpuReset, LoadInstructions, busy, done, error;
  logic [31:0] Instruction;

  int          tests_run = 0;
  int          tests_failed = 0;
  bit          mon_en = 1'b0;
  logic [31:0] sb [$];
  logic [31:0] prog [0:DEPTH-1];

  boot_loader #(.DEPTH(DEPTH), .AW(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Reset(Reset), .load_req(load_req), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .CpuReset(CpuReset),
    .LoadInstructions(LoadInstructions), .Instruction(Instruction),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (LoadInstructions === 1'b1) begin
        if (sb.size() == 0) check("unexpected_load", LoadInstructions, 1'b0);
        else begin
          check("instr", Instruction, sb.pop_front());
          check("stream_cpureset", CpuReset, 1'b0);
          check("stream_ready", byte_ready, 1'b0);
        end
      end else begin
        check("instr_idle", Instruction, 32'h0);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_cpureset", CpuReset, 1'b1);
    check("rst_load", LoadInstructions, 1'b0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_ready", byte_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (byte_ready !== 1'b1 && guard < 2000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) check("byte_accept_timeout", byte_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic load_program(input int n, input bit bad_csum);
    logic [7:0]  s;
    logic [31:0] w;
    s = 8'd0;
    pulse_load();
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      w = prog[k];
      for (int b = 3; b >= 0; b--) begin
        send_byte(w[8*b +: 8]);
        s = s + w[8*b +: 8];
      end
      if (!bad_csum) sb.push_back(w);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? s + 8'd1 : s);
`endif
    byte_valid = 1'b0;
  endtask

  task automatic expect_stream(input int n, input bit poke);
    int cnt, waitc;
    cnt = 0;
    waitc = 0;
    @(negedge clk);
    while (LoadInstructions !== 1'b1 && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    while (LoadInstructions === 1'b1 && cnt <= 300) begin
      cnt++;
      load_req = (poke && cnt == 2);
      @(negedge clk);
    end
    load_req = 1'b0;
    check("stream_len", cnt, n);
    check("restart_cpureset", CpuReset, 1'b1);
    check("restart_done", done, 1'b0);
    @(negedge clk);
    check("run_done", done, 1'b1);
    check("run_cpureset", CpuReset, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; load_req = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;

    // basic two-word program
    prog[0] = 32'h20010005;
    prog[1] = 32'h8C020000;
    load_program(2, 1'b0);
    expect_stream(2, 1'b0);
    @(posedge clk); #1;

    // zero and oversize headers
    pulse_load();
    send_byte(8'h00);
    byte_valid = 1'b0;
    @(negedge clk);
    check("hdr0_error", error, 1'b1);
    check("hdr0_cpureset", CpuReset, 1'b1);
    check("hdr0_busy", busy, 1'b0);
    @(posedge clk); #1;
    pulse_load();
    send_byte(8'(DEPTH + 1));
    byte_valid = 1'b0;
    @(negedge clk);
    check("hdr_big_error", error, 1'b1);
    @(posedge clk); #1;
    prog[0] = 32'hDEADBEEF;
    load_program(1, 1'b0);
    expect_stream(1, 1'b0);
    @(posedge clk); #1;

    // full buffer
    for (int k = 0; k < DEPTH; k++)
      prog[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    load_program(DEPTH, 1'b0);
    expect_stream(DEPTH, 1'b0);
    @(posedge clk); #1;

    // idle timeout in DATA
    pulse_load();
    send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    byte_valid = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    check("pre_timeout_error", error, 1'b0);
    check("pre_timeout_busy", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("timeout_error", error, 1'b1);
    check("timeout_cpureset", CpuReset, 1'b1);
    @(posedge clk); #1;

    // reset mid-DATA
    pulse_load();
    send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    byte_valid = 1'b0;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;

    // held byte and ignored load_req during STREAM, then RUN
    prog[0] = 32'h01234567;
    prog[1] = 32'h89ABCDEF;
    prog[2] = 32'h0F1E2D3C;
    load_program(3, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'h01;
    expect_stream(3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("run_ready", byte_ready, 1'b0);
      check("run_done_hold", done, 1'b1);
    end
    @(posedge clk); #1;
    prog[0] = 32'hCAFEF00D;
    load_program(1, 1'b0);
    expect_stream(1, 1'b0);
    @(posedge clk); #1;

    // Reset wins over a simultaneous load_req
    Reset = 1'b1;
    load_req = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    load_req = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;

`ifdef BOOT_LOADER_CHECKSUM_EN
    prog[0] = 32'h01020304;
    load_program(1, 1'b0);
    expect_stream(1, 1'b0);
    @(posedge clk); #1;
    load_program(1, 1'b1);
    @(negedge clk);
    check("csum_bad_error", error, 1'b1);
    check("csum_bad_cpureset", CpuReset, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("csum_bad_noload", LoadInstructions, 1'b0);
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
